// File: rtl/hog_pkg.sv
// Shared definitions for the HOG cell-histogram slice.
// Holds the bin count, the bin index type and the Q4.16 tangent thresholds
// that separate the nine 20-degree unsigned-orientation bins. The same
// constants are used by the gradient divider's output clamp.
package hog_pkg;

  localparam int unsigned NUM_BINS = 9;
  localparam int unsigned TAN_W    = 20;

  typedef logic [3:0] bin_t;

  // Positive-slope thresholds: tan(20), tan(40), tan(60), tan(80).
  localparam logic signed [TAN_W-1:0] T20    = 20'sh05D2D;
  localparam logic signed [TAN_W-1:0] T40    = 20'sh0D6CF;
  localparam logic signed [TAN_W-1:0] T60    = 20'sh1BB68;
  localparam logic signed [TAN_W-1:0] T80    = 20'sh5ABD9;
  // Negative-slope thresholds: tan(160), tan(140), tan(120), tan(100).
  localparam logic signed [TAN_W-1:0] N20    = 20'shFA2D3;
  localparam logic signed [TAN_W-1:0] N40    = 20'shF2931;
  localparam logic signed [TAN_W-1:0] N60    = 20'shE4498;
  localparam logic signed [TAN_W-1:0] TAN100 = 20'shA5426;

endpackage

// File: rtl/hog_tan_bin.sv
// Combinational orientation classifier: maps a signed Q4.16 quotient
// t = gy/gx onto one of nine 20-degree unsigned-orientation bins.
// Ports:
//   tan - signed quotient from the divider (T_W bits)
//   bin - bin index 0..8
module hog_tan_bin
  import hog_pkg::*;
#(
  parameter int unsigned T_W = 20
) (
  input  logic [T_W-1:0] tan,
  output bin_t           bin
);

  localparam logic signed [T_W-1:0] P1 = T_W'(T20);
  localparam logic signed [T_W-1:0] P2 = T_W'(T40);
  localparam logic signed [T_W-1:0] P3 = T_W'(T60);
  localparam logic signed [T_W-1:0] P4 = T_W'(T80);
  localparam logic signed [T_W-1:0] M1 = T_W'(N20);
  localparam logic signed [T_W-1:0] M2 = T_W'(N40);
  localparam logic signed [T_W-1:0] M3 = T_W'(N60);
  localparam logic signed [T_W-1:0] M4 = T_W'(TAN100);

  logic signed [T_W-1:0] t;

  always_comb begin
    t = $signed(tan);
    if (t >= 0) begin
      if      (t < P1) bin = 4'd0;
      else if (t < P2) bin = 4'd1;
      else if (t < P3) bin = 4'd2;
      else if (t < P4) bin = 4'd3;
      else             bin = 4'd4;
    end else begin
      // Both clamp extremes (near-vertical gradients and gx=0) land in bin 4.
      if      (t <= M4) bin = 4'd4;
      else if (t <= M3) bin = 4'd5;
      else if (t <= M2) bin = 4'd6;
      else if (t <= M1) bin = 4'd7;
      else              bin = 4'd8;
    end
  end

endmodule

// File: rtl/hog_cell_hist.sv
// HOG cell histogram: classifies each pixel's orientation quotient into one
// of nine bins, accumulates gradient magnitude per bin over CELL_PIX pixels,
// then presents the finished histogram until downstream takes it.
// Build option: define HOG_BIN_SAT_EN to saturate each bin at 2^HIST_W-1;
// otherwise bin adds wrap modulo 2^HIST_W.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_valid/i_ready   - pixel sample handshake (i_tan, i_mag)
//   o_valid/o_ready   - histogram handshake (o_hist, bin k at [k*HIST_W +: HIST_W])
module hog_cell_hist
  import hog_pkg::*;
#(
  parameter int unsigned T_W      = 20,
  parameter int unsigned MAG_W    = 9,
  parameter int unsigned HIST_W   = 16,
  parameter int unsigned CELL_PIX = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [T_W-1:0]             i_tan,
  input  logic [MAG_W-1:0]           i_mag,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [NUM_BINS*HIST_W-1:0] o_hist
);

  localparam int unsigned CNT_W = $clog2(CELL_PIX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_PIX - 1);

  typedef enum logic [1:0] {StAccum, StFlush, StHold} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             clear;
  logic             accept;

  bin_t             cls_bin;
  logic             s1_valid_q;
  bin_t             s1_bin_q;
  logic [MAG_W-1:0] s1_mag_q;

  logic [HIST_W-1:0] hist_q [NUM_BINS];
  logic [HIST_W-1:0] cur_val, new_val;

  hog_tan_bin #(
    .T_W (T_W)
  ) u_tan_bin (
    .tan (i_tan),
    .bin (cls_bin)
  );

  assign accept = i_valid & i_ready;

  // Control FSM ----------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    clear   = 1'b0;
    i_ready = 1'b0;
    o_valid = 1'b0;
    unique case (state_q)
      StAccum: begin
        i_ready = 1'b1;
        if (i_valid) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = StFlush;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFlush: begin
        // Two cycles let the last sample pass S1 and land in its bin.
        flush_d = ~flush_q;
        if (flush_q) state_d = StHold;
      end
      StHold: begin
        o_valid = 1'b1;
        if (o_ready) begin
          clear   = 1'b1;
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccum;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  // Stage S1: registered classification --------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      s1_mag_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_bin_q   <= cls_bin;
      s1_mag_q   <= i_mag;
    end
  end

  // Stage S2: read-modify-write of the selected bin ---------------------
`ifdef HOG_BIN_SAT_EN
  logic [HIST_W:0] sum_wide;

  always_comb begin
    cur_val  = hist_q[s1_bin_q];
    sum_wide = {1'b0, cur_val} + (HIST_W + 1)'(s1_mag_q);
    new_val  = sum_wide[HIST_W] ? '1 : sum_wide[HIST_W-1:0];
  end
`else
  always_comb begin
    cur_val = hist_q[s1_bin_q];
    new_val = cur_val + HIST_W'(s1_mag_q);
  end
`endif

  // clear only fires in StHold, when S1 is guaranteed empty.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < NUM_BINS; k++) hist_q[k] <= '0;
    end else if (s1_valid_q) begin
      hist_q[s1_bin_q] <= new_val;
    end
  end

  always_comb begin
    o_hist = '0;
    for (int k = 0; k < NUM_BINS; k++) o_hist[k*HIST_W +: HIST_W] = hist_q[k];
  end

endmodule

// File: tb/tb_hog_cell_hist.sv
module tb_hog_cell_hist;

  localparam int T_W      = 20;
  localparam int MAG_W    = 9;
  localparam int HIST_W   = 12;
  localparam int CELL_PIX = 64;
  localparam int NB       = 9;
  localparam int MAXV     = (1 << HIST_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    i_valid;
  logic                    i_ready;
  logic [T_W-1:0]          i_tan;
  logic [MAG_W-1:0]        i_mag;
  logic                    o_valid;
  logic                    o_ready;
  logic [NB*HIST_W-1:0]    o_hist;

  logic [T_W-1:0]          c_tan;
  logic [3:0]              c_bin;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hog_cell_hist #(
    .T_W      (T_W),
    .MAG_W    (MAG_W),
    .HIST_W   (HIST_W),
    .CELL_PIX (CELL_PIX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_tan   (i_tan),
    .i_mag   (i_mag),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_hist  (o_hist)
  );

  hog_tan_bin #(
    .T_W (T_W)
  ) u_cls (
    .tan (c_tan),
    .bin (c_bin)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference classification from the angle thresholds as plain integers.
  function automatic int ref_bin(input logic [19:0] raw);
    int t;
    int b;
    int pos[4];
    int neg[4];
    pos = '{'h5D2D, 'hD6CF, 'h1BB68, 'h5ABD9};
    neg = '{-'h5D2D, -'hD6CF, -'h1BB68, -'h5ABDA};
    t = int'($signed(raw));
    if (t >= 0) begin
      b = 0;
      for (int i = 0; i < 4; i++) if (t >= pos[i]) b++;
    end else begin
      b = 8;
      for (int i = 0; i < 4; i++) if (t <= neg[i]) b--;
    end
    return b;
  endfunction

  function automatic int add_bin(input int b, input int m);
`ifdef HOG_BIN_SAT_EN
    return (b + m > MAXV) ? MAXV : b + m;
`else
    return (b + m) & MAXV;
`endif
  endfunction

  // Transaction-level model: bins, samples in the current cell, drain delay.
  int m_bins[NB];
  int m_cnt   = 0;
  int m_drain = 0;
  bit m_hold  = 1'b0;
  bit m_acc   = 1'b0;
  bit chk_en  = 1'b0;

  initial forever begin
    int b;
    @(posedge clk);
    m_acc = 1'b0;
    if (rst) begin
      for (int k = 0; k < NB; k++) m_bins[k] = 0;
      m_cnt   = 0;
      m_drain = 0;
      m_hold  = 1'b0;
    end else if (m_hold) begin
      if (o_ready) begin
        for (int k = 0; k < NB; k++) m_bins[k] = 0;
        m_hold = 1'b0;
      end
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) m_hold = 1'b1;
    end else if (i_valid) begin
      m_acc = 1'b1;
      b = ref_bin(i_tan);
      m_bins[b] = add_bin(m_bins[b], int'(i_mag));
      m_cnt++;
      if (m_cnt == CELL_PIX) begin
        m_cnt   = 0;
        m_drain = 2;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("i_ready", 32'(i_ready), 32'(!(m_hold || m_drain > 0)));
      chk("o_valid", 32'(o_valid), 32'(m_hold));
      if (m_hold) begin
        for (int k = 0; k < NB; k++)
          chk($sformatf("hist_bin%0d", k), 32'(o_hist[k*HIST_W +: HIST_W]), 32'(m_bins[k]));
      end
    end
  end

  task automatic send(input logic [19:0] t, input logic [8:0] m);
    int n;
    n       = 0;
    i_valid = 1'b1;
    i_tan   = t;
    i_mag   = m;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_acc && n < 400);
    if (!m_acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_hold(input string name);
    int n;
    n = 0;
    while (!m_hold && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!m_hold) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic release_cell();
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 1'b0;
  endtask

  task automatic chk_bin(input string name, input int k, input int exp);
    chk(name, 32'(o_hist[k*HIST_W +: HIST_W]), 32'(exp));
  endtask

  initial begin
    logic [19:0] ct[20];
    int          cb[20];
    logic [19:0] edge_t[14];
    logic [19:0] t6[6];
    int          bb[9];

    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] ct[20];
    int          cb[20];
    logic [19:0] edge_t[14];
    logic [19:0] t6[6];
    int          exp_b[9];

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; i_tan = '0; i_mag = '0; c_tan = '0;

    // Standalone classifier against hand-derived bins at every threshold.
    ct = '{20'h00000, 20'h05D2C, 20'h05D2D, 20'h0D6CE, 20'h0D6CF, 20'h1BB67, 20'h1BB68,
           20'h5ABD8, 20'h5ABD9, 20'h7FFFF, 20'hA5426, 20'hA5427, 20'hE4498, 20'hE4499,
           20'hF2931, 20'hF2932, 20'hFA2D3, 20'hFA2D4, 20'hFFFFF, 20'h80000};
    cb = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 4, 5, 5, 6, 6, 7, 7, 8, 8, 4};
    for (int i = 0; i < 20; i++) begin
      c_tan = ct[i];
      #1;
      chk($sformatf("cls_%05h", ct[i]), 32'(c_bin), 32'(cb[i]));
      chk($sformatf("model_%05h", ct[i]), 32'(ref_bin(ct[i])), 32'(cb[i]));
    end

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_hist_zero", 32'(o_hist == '0), 32'd1);

    // Cell of t=0, mag=1, with explicit latency check.
    repeat (CELL_PIX) send(20'h00000, 9'd1);
    i_valid = 1'b0;
    @(negedge clk); chk("lat_n0", 32'(o_valid), 32'd0);
    @(negedge clk); chk("lat_n1", 32'(o_valid), 32'd0);
    @(negedge clk); chk("lat_n2", 32'(o_valid), 32'd1);
    chk_bin("t1_bin0", 0, 64);
    for (int k = 1; k < NB; k++) chk_bin($sformatf("t1_bin%0d", k), k, 0);
    @(posedge clk); #1;
    release_cell();

    // Boundary values, mag 3, padded with T60 mag 0.
    t6 = '{20'h05D2C, 20'h05D2D, 20'h5ABD9, 20'hA5426, 20'hA5427, 20'hFFFFF};
    for (int i = 0; i < 6; i++) send(t6[i], 9'd3);
    repeat (CELL_PIX - 6) send(20'h1BB68, 9'd0);
    i_valid = 1'b0;
    wait_hold("t2");
    exp_b = '{3, 3, 0, 0, 6, 3, 0, 0, 3};
    for (int k = 0; k < NB; k++) chk_bin($sformatf("t2_bin%0d", k), k, exp_b[k]);

    // Stall in HOLD with i_valid asserted: samples must be ignored.
    i_valid = 1'b1;
    repeat (10) begin
      i_tan = 20'($urandom);
      i_mag = 9'($urandom);
      @(posedge clk); #1;
    end
    chk("hold_o_valid", 32'(o_valid), 32'd1);
    chk("hold_i_ready", 32'(i_ready), 32'd0);
    i_valid = 1'b0;
    release_cell();
    chk("post_rel_bin4", 32'(o_hist[4*HIST_W +: HIST_W]), 32'd0);

    // Overflow of bin2: 64 * 511.
    repeat (CELL_PIX) send(20'h0D6CF, 9'd511);
    i_valid = 1'b0;
    wait_hold("t3");
`ifdef HOG_BIN_SAT_EN
    chk_bin("t3_bin2_sat", 2, 4095);
`else
    chk_bin("t3_bin2_wrap", 2, 4032);
`endif
    release_cell();

    // Reset mid-cell discards partial data.
    repeat (30) send(20'($urandom), 9'($urandom));
    i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (CELL_PIX) send(20'h00000, 9'd2);
    i_valid = 1'b0;
    wait_hold("t4");
    chk_bin("t4_bin0", 0, 128);
    for (int k = 1; k < NB; k++) chk_bin($sformatf("t4_bin%0d", k), k, 0);
    release_cell();

    // Back-to-back across cell boundaries with downstream always ready.
    o_ready = 1'b1;
    repeat (3 * CELL_PIX) send(20'($urandom), 9'($urandom));
    i_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    o_ready = 1'b0;

    // Fully randomized traffic with threshold-biased quotients.
    edge_t = '{20'h05D2C, 20'h05D2D, 20'h0D6CE, 20'h0D6CF, 20'h1BB67, 20'h1BB68, 20'h5ABD9,
               20'hA5426, 20'hA5427, 20'hE4498, 20'hE4499, 20'hF2931, 20'hFA2D3, 20'hFA2D4};
    repeat (800) begin
      @(posedge clk); #1;
      i_valid = ($urandom % 4) != 0;
      i_tan   = ($urandom % 2) ? edge_t[$urandom % 14] : 20'($urandom);
      i_mag   = 9'($urandom_range(0, 511));
      o_ready = ($urandom % 3) == 0;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
